// File: rtl/pipe_stage_skid_if.sv
// Valid/ready beat channel carrying a control bus and a packed payload.
// The producer uses the master modport and the consumer uses the slave modport.
interface pipe_stage_skid_if #(
    parameter int CTRL_W = 36,
    parameter int DATA_W = 256
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input ready);
    modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer, registered in_ready,
// a flush that inserts a bubble, and a saturating stall-cycle counter.
module pipe_stage_skid #(
    parameter int CTRL_W = 36,
    parameter int DATA_W = 256,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rset,
    input  logic                 flush,
    pipe_stage_skid_if.slave     up,
    pipe_stage_skid_if.master    down,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     stall_cnt
);
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]        state_reg, state_next;
    logic [CTRL_W-1:0] main_ctrl_reg, main_ctrl_next;
    logic [DATA_W-1:0] main_data_reg, main_data_next;
    logic [CTRL_W-1:0] skid_ctrl_reg, skid_ctrl_next;
    logic [DATA_W-1:0] skid_data_reg, skid_data_next;
    logic              in_ready_reg;
    logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;

    logic out_valid;
    logic in_fire;
    logic out_fire;

    assign out_valid = (state_reg != ST_EMPTY);
    assign in_fire   = up.valid & in_ready_reg;
    assign out_fire  = out_valid & down.ready;

    always_comb begin
        state_next     = state_reg;
        main_ctrl_next = main_ctrl_reg;
        main_data_next = main_data_reg;
        skid_ctrl_next = skid_ctrl_reg;
        skid_data_next = skid_data_reg;
        if (flush) begin
            // Payload registers keep their contents so out_data holds its last value.
            state_next = ST_EMPTY;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_ctrl_next = up.ctrl;
                        main_data_next = up.data;
                        state_next     = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_ctrl_next = up.ctrl;
                        main_data_next = up.data;
                    end else if (in_fire) begin
                        skid_ctrl_next = up.ctrl;
                        skid_data_next = up.data;
                        state_next     = ST_FULL;
                    end else if (out_fire) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_ctrl_next = skid_ctrl_reg;
                        main_data_next = skid_data_reg;
                        state_next     = ST_ONE;
                    end
                end
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (cnt_clr) begin
            stall_cnt_next = '0;
        end else if (out_valid && !down.ready && stall_cnt_reg != CNT_MAX) begin
            stall_cnt_next = stall_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            state_reg     <= ST_EMPTY;
            main_ctrl_reg <= '0;
            main_data_reg <= '0;
            skid_ctrl_reg <= '0;
            skid_data_reg <= '0;
            in_ready_reg  <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            main_ctrl_reg <= main_ctrl_next;
            main_data_reg <= main_data_next;
            skid_ctrl_reg <= skid_ctrl_next;
            skid_data_reg <= skid_data_next;
            // Ready is computed from the next state so no path runs from down.ready to up.ready.
            in_ready_reg  <= (state_next != ST_FULL);
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_gate
            assign down.ctrl[gi] = main_ctrl_reg[gi] & out_valid;
        end
    endgenerate

    assign down.valid = out_valid;
    assign down.data  = main_data_reg;
    assign up.ready   = in_ready_reg;
    assign stall_cnt  = stall_cnt_reg;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomized checks of pipe_stage_skid against a queue-based model
// of the beats held inside the stage.
module tb_pipe_stage_skid;
    localparam int CTRL_W = 36;
    localparam int DATA_W = 256;
    localparam int CNT_W  = 4;
    localparam int BW     = CTRL_W + DATA_W;

    typedef logic [BW-1:0] beat_t;

    logic             clk = 1'b0;
    logic             rset;
    logic             flush;
    logic             cnt_clr;
    logic [CNT_W-1:0] stall_cnt;

    pipe_stage_skid_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) up_if ();
    pipe_stage_skid_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dn_if ();

    pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rset      (rset),
        .flush     (flush),
        .up        (up_if),
        .down      (dn_if),
        .cnt_clr   (cnt_clr),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference: the beats currently held, in acceptance order.
    beat_t             q[$];
    logic              m_ready;
    logic [CNT_W-1:0]  m_cnt;
    logic [DATA_W-1:0] last_data;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ready   = 1'b0;
        m_cnt     = '0;
        last_data = '0;
    endtask

    task automatic model_edge();
        logic in_f;
        logic out_f;
        in_f  = up_if.valid && m_ready;
        out_f = (q.size() > 0) && dn_if.ready;
        if (cnt_clr)
            m_cnt = '0;
        else if (q.size() > 0 && !dn_if.ready && m_cnt != 4'd15)
            m_cnt = m_cnt + 4'd1;
        if (flush) begin
            q.delete();
        end else begin
            if (out_f) void'(q.pop_front());
            if (in_f) q.push_back({up_if.ctrl, up_if.data});
        end
        m_ready = (q.size() < 2);
        if (q.size() > 0) last_data = q[0][DATA_W-1:0];
    endtask

    task automatic check_all();
        beat_t head;
        logic  exp_valid;
        head      = '0;
        exp_valid = 1'b0;
        if (q.size() > 0) begin
            head      = q[0];
            exp_valid = 1'b1;
        end
        check("out_valid", BW'(dn_if.valid), BW'(exp_valid));
        check("in_ready", BW'(up_if.ready), BW'(m_ready));
        check("out_ctrl", BW'(dn_if.ctrl), exp_valid ? BW'(head[BW-1:DATA_W]) : '0);
        check("out_data", BW'(dn_if.data), exp_valid ? BW'(head[DATA_W-1:0]) : BW'(last_data));
        check("stall_cnt", BW'(stall_cnt), BW'(m_cnt));
    endtask

    // Drive one cycle's inputs at the falling edge, advance through the rising edge, check at the next falling edge.
    task automatic cycle(input logic iv, input logic [CTRL_W-1:0] ic, input logic [DATA_W-1:0] id,
                         input logic ordy, input logic fl, input logic cc);
        up_if.valid = iv;
        up_if.ctrl  = ic;
        up_if.data  = id;
        dn_if.ready = ordy;
        flush       = fl;
        cnt_clr     = cc;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rset        = 1'b0;
        flush       = 1'b0;
        cnt_clr     = 1'b0;
        up_if.valid = 1'b0;
        up_if.ctrl  = '0;
        up_if.data  = '0;
        dn_if.ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rset = 1'b1;
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        check("ready_after_release", BW'(up_if.ready), BW'(1'b1));

        // Streaming: 8 back-to-back beats, each visible one cycle after acceptance.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, CTRL_W'(i + 1), DATA_W'(i), 1'b1, 1'b0, 1'b0);
            check("stream_data", BW'(dn_if.data), BW'(i));
            check("stream_ready", BW'(up_if.ready), BW'(1'b1));
        end
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Back-pressure: A in main, B in skid, C held upstream, then drain in order.
        cycle(1'b1, 36'hA, 256'hA0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 36'hB, 256'hB0, 1'b0, 1'b0, 1'b0);
        check("bp_full_ready", BW'(up_if.ready), BW'(1'b0));
        cycle(1'b1, 36'hC, 256'hC0, 1'b0, 1'b0, 1'b0);
        check("bp_hold_A", BW'(dn_if.data), BW'(256'hA0));
        cycle(1'b1, 36'hC, 256'hC0, 1'b1, 1'b0, 1'b0);
        check("bp_then_B", BW'(dn_if.data), BW'(256'hB0));
        cycle(1'b1, 36'hC, 256'hC0, 1'b1, 1'b0, 1'b0);
        check("bp_then_C", BW'(dn_if.data), BW'(256'hC0));
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        check("bp_drained", BW'(dn_if.valid), BW'(1'b0));

        // Flush while full with an incoming all-ones control beat.
        cycle(1'b1, 36'h1D, 256'hD0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 36'h1E, 256'hE0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 36'hFFFFFFFFF, 256'hF0, 1'b0, 1'b1, 1'b0);
        check("flush_ctrl", BW'(dn_if.ctrl), '0);
        check("flush_ready", BW'(up_if.ready), BW'(1'b1));
        repeat (3) cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset between edges while full.
        cycle(1'b1, 36'h21, 256'h210, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 36'h22, 256'h220, 1'b0, 1'b0, 1'b0);
        #2 rset = 1'b0;
        #1;
        model_reset();
        check_all();
        check("rst_ctrl", BW'(dn_if.ctrl), '0);
        @(negedge clk);
        rset = 1'b1;
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        check("rst_release_ready", BW'(up_if.ready), BW'(1'b1));

        // Saturating stall counter and clear priority.
        cycle(1'b1, 36'h5, 256'h55, 1'b0, 1'b0, 1'b1);
        repeat (20) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        check("cnt_saturate", BW'(stall_cnt), BW'(4'd15));
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        check("cnt_clear", BW'(stall_cnt), '0);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        check("cnt_one", BW'(stall_cnt), BW'(4'd1));
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        check("cnt_two", BW'(stall_cnt), BW'(4'd2));

        // Randomized traffic with occasional flush and counter clear.
        for (int n = 0; n < 10000; n++) begin
            logic [CTRL_W-1:0] rc;
            logic [DATA_W-1:0] rd;
            rc = {$urandom, $urandom};
            for (int w = 0; w < DATA_W / 32; w++) rd[w*32 +: 32] = $urandom;
            cycle(1'($urandom_range(0, 1)), rc, rd, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
